// File: rtl/sha256_round_core.sv
// sha256_round_core: SHA-256 compression rounds over a streamed W schedule; SHA_ZERO_CHECK_EN adds zero_hi
module sha256_round_core #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic         w_valid,
  input  logic [31:0]  w_word,
  output logic         w_ready,
  output logic         busy,
  output logic [6:0]   round,
  output logic         done,
  output logic [255:0] digest
`ifdef SHA_ZERO_CHECK_EN
  ,
  output logic         zero_hi
`endif
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  state_t state, state_nx;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] s0, s1, ch, maj, t1, t2;
  logic [255:0] hs, sum;
  logic beat;
  assign w_ready = state == ROUND;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign beat    = w_ready && w_valid;
  always_comb begin
    s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    ch  = (e & f) ^ (~e & g);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t1  = h + s1 + ch + K[round[5:0]] + w_word;
    t2  = s0 + maj;
    sum = {hs[255:224] + a, hs[223:192] + b, hs[191:160] + c, hs[159:128] + d,
           hs[127:96] + e, hs[95:64] + f, hs[63:32] + g, hs[31:0] + h};
  end
  always_comb begin
    state_nx = state == IDLE  ? (start ? ROUND : IDLE) :
               state == ROUND ? ((beat && round == LAST) ? FINAL : ROUND) :
               state == FINAL ? DONE : IDLE;
  end
  always_ff @(posedge clk)
    state <= !n_rst ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (!n_rst) begin
      {a, b, c, d, e, f, g, h} <= '0;
      hs     <= '0;
      digest <= '0;
      round  <= '0;
`ifdef SHA_ZERO_CHECK_EN
      zero_hi <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      hs    <= h_in;
      {a, b, c, d, e, f, g, h} <= h_in;
      round <= '0;
    end else if (beat) begin
      {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
      round <= round + 7'd1;
    end else if (state == FINAL) begin
      digest <= sum;
`ifdef SHA_ZERO_CHECK_EN
      zero_hi <= sum[255:224] == 32'h0;
`endif
    end
endmodule
